rf_recovery_seq: RTL and testbench

- Sequencer directly downstream of the fault-tolerance control FSM in the duplex-core fault-tolerance module.
- Consumes that FSM's recovery request (`recover`) and produces its `recovery_done` input.
- On a request, copies the architectural state of the healthy core (GPRs x1..x(NREGS-1) and the PC) into both cores' register files, one register per cycle.
- Then signals completion and holds it until the next request.

---
 rtl/rf_recovery_seq.sv | 158 +++++++++++++++
 tb/tb_rf_recovery_seq.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_recovery_seq.sv
// rf_recovery_seq: after a fault, copies the healthy core's GPRs x1..x(NREGS-1) and PC into both
// cores, one register per cycle. Define RF_RECOVERY_VERIFY_EN to add a readback compare pass.
`timescale 1ns/1ps
module rf_recovery_seq #(
  parameter int unsigned NREGS  = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              recover_i,
  input  logic              src_sel_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [DATA_W-1:0] rd_data_a_i,
  input  logic [DATA_W-1:0] rd_data_b_i,
  input  logic [DATA_W-1:0] pc_a_i,
  input  logic [DATA_W-1:0] pc_b_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              pc_we_o,
  output logic [DATA_W-1:0] pc_o,
  output logic              busy_o,
  output logic              recovery_done_o,
  output logic              verify_err_o
);

  typedef enum logic [2:0] {StIdle, StCopy, StPc, StVerify, StDone} state_e;

  localparam logic [ADDR_W-1:0] FirstAddr = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(NREGS - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                src_q, src_d;
  logic                recover_q;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                done_q, done_d;
  logic                start;
`ifdef RF_RECOVERY_VERIFY_EN
  logic                verr_q, verr_d;
`endif

  // DONE accepts a new request exactly like IDLE; only the done flag differs.
  assign start = recover_i & ~recover_q & ((state_q == StIdle) | (state_q == StDone));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      src_q     <= 1'b0;
      recover_q <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
`ifdef RF_RECOVERY_VERIFY_EN
      verr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      src_q     <= src_d;
      recover_q <= recover_i;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
`ifdef RF_RECOVERY_VERIFY_EN
      verr_q    <= verr_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    src_d     = src_q;
    wr_en_d   = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;
    done_d    = done_q;
`ifdef RF_RECOVERY_VERIFY_EN
    verr_d    = verr_q;
`endif

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          src_d   = src_sel_i;
          done_d  = 1'b0;
`ifdef RF_RECOVERY_VERIFY_EN
          verr_d  = 1'b0;
`endif
          cnt_d   = FirstAddr;
          state_d = StCopy;
        end
      end
      StCopy: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q;
        wr_data_d = src_q ? rd_data_b_i : rd_data_a_i;
        if (cnt_q == LastAddr) begin
          cnt_d   = '0;
          state_d = StPc;
        end else begin
          cnt_d   = cnt_q + FirstAddr;
        end
      end
      StPc: begin
`ifdef RF_RECOVERY_VERIFY_EN
        cnt_d   = FirstAddr;
        state_d = StVerify;
`else
        cnt_d   = '0;
        done_d  = 1'b1;
        state_d = StDone;
`endif
      end
`ifdef RF_RECOVERY_VERIFY_EN
      StVerify: begin
        // Both cores should now hold identical contents; any difference is sticky.
        if (rd_data_a_i != rd_data_b_i) begin
          verr_d = 1'b1;
        end
        if (cnt_q == LastAddr) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d   = cnt_q + FirstAddr;
        end
      end
`endif
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  assign rd_addr_o       = ((state_q == StCopy) | (state_q == StVerify)) ? cnt_q : '0;
  assign pc_we_o         = (state_q == StPc);
  assign pc_o            = pc_we_o ? (src_q ? pc_b_i : pc_a_i) : '0;
  assign busy_o          = (state_q == StCopy) | (state_q == StPc) | (state_q == StVerify);
  assign wr_en_o         = wr_en_q;
  assign wr_addr_o       = wr_addr_q;
  assign wr_data_o       = wr_data_q;
  assign recovery_done_o = done_q;
`ifdef RF_RECOVERY_VERIFY_EN
  assign verify_err_o    = verr_q;
`else
  assign verify_err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_rf_recovery_seq.sv
// Directed bench for rf_recovery_seq; models both core register files and writes them back.
`timescale 1ns/1ps
module tb_rf_recovery_seq;

  localparam int unsigned NREGS  = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
`ifdef RF_RECOVERY_VERIFY_EN
  localparam bit          VERIFY_ON = 1'b1;
  localparam int unsigned DONE_EDGE = 2 * NREGS - 1;
`else
  localparam bit          VERIFY_ON = 1'b0;
  localparam int unsigned DONE_EDGE = NREGS;
`endif
  localparam logic [DATA_W-1:0] PC_A = 32'h8000_0100;
  localparam logic [DATA_W-1:0] PC_B = 32'h8000_0200;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              recover = 1'b0;
  logic              src_sel = 1'b0;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data_a, rd_data_b;
  logic [DATA_W-1:0] pc_a = PC_A;
  logic [DATA_W-1:0] pc_b = PC_B;
  logic              wr_en, pc_we, busy, done, verr;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data, pc_out;

  logic [DATA_W-1:0] rf_a [NREGS];
  logic [DATA_W-1:0] rf_b [NREGS];
  bit                corrupt = 1'b0;
  int                n_checks = 0;
  int                n_fail = 0;

  always #5 clk = ~clk;

  assign rd_data_a = rf_a[rd_addr];
  assign rd_data_b = rf_b[rd_addr];

  rf_recovery_seq #(.NREGS(NREGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .recover_i       (recover),
    .src_sel_i       (src_sel),
    .rd_addr_o       (rd_addr),
    .rd_data_a_i     (rd_data_a),
    .rd_data_b_i     (rd_data_b),
    .pc_a_i          (pc_a),
    .pc_b_i          (pc_b),
    .wr_en_o         (wr_en),
    .wr_addr_o       (wr_addr),
    .wr_data_o       (wr_data),
    .pc_we_o         (pc_we),
    .pc_o            (pc_out),
    .busy_o          (busy),
    .recovery_done_o (done),
    .verify_err_o    (verr)
  );

  task automatic init_rf(input logic [DATA_W-1:0] base_a, input logic [DATA_W-1:0] base_b);
    for (int i = 0; i < int'(NREGS); i++) begin
      rf_a[i] = base_a + DATA_W'(i);
      rf_b[i] = base_b + DATA_W'(i);
    end
  endtask

  // One clock: both cores commit the strobe visible before the edge; outputs sampled 1ns after.
  task automatic step();
    logic              en;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    en = wr_en;
    a  = wr_addr;
    d  = wr_data;
    @(posedge clk);
    #1;
    if (en === 1'b1) begin
      rf_a[a] = d;
      rf_b[a] = d;
      if (corrupt && a == ADDR_W'(7)) rf_b[a] = d ^ 32'hDEAD_BEEF;
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({wr_en, pc_we, busy, done, verr} !== 5'b0 || rd_addr !== '0 || pc_out !== '0 ||
        wr_addr !== '0 || wr_data !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got en/pcwe/busy/done/err=%b rd=%0h pc=%0h wa=%0h wd=%0h, want all 0",
               {wr_en, pc_we, busy, done, verr}, rd_addr, pc_out, wr_addr, wr_data);
    end
    step();
    step();
    rst = 1'b0;
    step();
    n_checks++;
    if ({wr_en, pc_we, busy, done, verr} !== 5'b0 || rd_addr !== '0 || pc_out !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: got en/pcwe/busy/done/err=%b rd=%0h pc=%0h, want 0",
               {wr_en, pc_we, busy, done, verr}, rd_addr, pc_out);
    end
  endtask

  task automatic test_copy_a();
    init_rf(32'h1000, 32'h2000);
    src_sel = 1'b0;
    recover = 1'b1;
    step();
    n_checks++;
    if ({busy, done, wr_en, pc_we, verr} !== 5'b10000 || rd_addr !== ADDR_W'(1)) begin
      n_fail++;
      $display("FAIL copy_a_e0: got busy/done/en/pcwe/err=%b rd=%0h, want 10000 rd=1",
               {busy, done, wr_en, pc_we, verr}, rd_addr);
    end
    for (int k = 1; k < int'(NREGS); k++) begin
      step();
      if (k == 1) recover = 1'b0;
      n_checks++;
      if ({wr_en, busy} !== 2'b11 || wr_addr !== ADDR_W'(k) || wr_data !== 32'h1000 + DATA_W'(k)) begin
        n_fail++;
        $display("FAIL copy_a_write%0d: got en=%b addr=%0d data=%0h, want en=1 addr=%0d data=%0h",
                 k, wr_en, wr_addr, wr_data, k, 32'h1000 + k);
      end
    end
    n_checks++;
    if (pc_we !== 1'b1 || pc_out !== PC_A) begin
      n_fail++;
      $display("FAIL copy_a_pc: got we=%b pc=%0h, want we=1 pc=%0h", pc_we, pc_out, PC_A);
    end
    for (int e = NREGS; e <= int'(DONE_EDGE); e++) begin
      n_checks++;
      if ({done, busy} !== 2'b01) begin
        n_fail++;
        $display("FAIL copy_a_predone_e%0d: got done/busy=%b, want 01", e, {done, busy});
      end
      step();
      if (e == int'(NREGS)) begin
        n_checks++;
        if ({wr_en, pc_we} !== 2'b00 || pc_out !== '0) begin
          n_fail++;
          $display("FAIL copy_a_after_pc: got en/pcwe=%b pc=%0h, want 00 pc=0",
                   {wr_en, pc_we}, pc_out);
        end
      end
    end
    n_checks++;
    if ({done, busy, verr} !== 3'b100) begin
      n_fail++;
      $display("FAIL copy_a_done: got done/busy/err=%b, want 100", {done, busy, verr});
    end
    for (int i = 0; i < 5; i++) step();
    n_checks++;
    if ({done, busy, wr_en, pc_we} !== 4'b1000) begin
      n_fail++;
      $display("FAIL copy_a_done_hold: got done/busy/en/pcwe=%b, want 1000",
               {done, busy, wr_en, pc_we});
    end
  endtask

  task automatic test_src_b();
    init_rf(32'h1000, 32'h2000);
    src_sel = 1'b1;
    recover = 1'b1;
    step();
    n_checks++;
    if ({done, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL src_b_e0_clear: got done/busy=%b, want 01", {done, busy});
    end
    for (int k = 1; k < int'(NREGS); k++) begin
      step();
      if (k == 1) recover = 1'b0;
      if (k == 5) src_sel = 1'b0;
      n_checks++;
      if (wr_en !== 1'b1 || wr_addr !== ADDR_W'(k) || wr_data !== 32'h2000 + DATA_W'(k)) begin
        n_fail++;
        $display("FAIL src_b_write%0d: got en=%b addr=%0d data=%0h, want en=1 addr=%0d data=%0h",
                 k, wr_en, wr_addr, wr_data, k, 32'h2000 + k);
      end
    end
    n_checks++;
    if (pc_we !== 1'b1 || pc_out !== PC_B) begin
      n_fail++;
      $display("FAIL src_b_pc: got we=%b pc=%0h, want we=1 pc=%0h", pc_we, pc_out, PC_B);
    end
    for (int e = NREGS; e <= int'(DONE_EDGE); e++) step();
    n_checks++;
    if ({done, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL src_b_done: got done/busy=%b, want 10", {done, busy});
    end
  endtask

  task automatic test_repulse();
    init_rf(32'h3000, 32'h2000);
    src_sel = 1'b0;
    recover = 1'b1;
    step();
    for (int k = 1; k < int'(NREGS); k++) begin
      step();
      if (k == 1) recover = 1'b0;
      if (k == 9) recover = 1'b1;
      if (k == 11) recover = 1'b0;
      n_checks++;
      if ({wr_en, busy} !== 2'b11 || wr_addr !== ADDR_W'(k) || wr_data !== 32'h3000 + DATA_W'(k)) begin
        n_fail++;
        $display("FAIL repulse_write%0d: got en=%b busy=%b addr=%0d data=%0h, want addr=%0d data=%0h",
                 k, wr_en, busy, wr_addr, wr_data, k, 32'h3000 + k);
      end
    end
    for (int e = NREGS; e <= int'(DONE_EDGE); e++) step();
    n_checks++;
    if ({done, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL repulse_done: got done/busy=%b, want 10", {done, busy});
    end
    recover = 1'b1;
    step();
    n_checks++;
    if ({done, busy, wr_en} !== 3'b010 || rd_addr !== ADDR_W'(1)) begin
      n_fail++;
      $display("FAIL rerun_e0: got done/busy/en=%b rd=%0h, want 010 rd=1", {done, busy, wr_en}, rd_addr);
    end
    for (int k = 1; k < int'(NREGS); k++) begin
      step();
      if (k == 1) recover = 1'b0;
      n_checks++;
      if (wr_en !== 1'b1 || wr_addr !== ADDR_W'(k)) begin
        n_fail++;
        $display("FAIL rerun_write%0d: got en=%b addr=%0d, want en=1 addr=%0d", k, wr_en, wr_addr, k);
      end
    end
    for (int e = NREGS; e <= int'(DONE_EDGE); e++) step();
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL rerun_done: got done=%b, want 1", done);
    end
  endtask

  task automatic test_reset_mid();
    int writes;
    int next_addr;
    init_rf(32'h1000, 32'h2000);
    src_sel = 1'b0;
    recover = 1'b1;
    step();
    for (int k = 1; k < 15; k++) begin
      step();
      if (k == 1) recover = 1'b0;
    end
    n_checks++;
    if (rd_addr !== ADDR_W'(15) || wr_addr !== ADDR_W'(14)) begin
      n_fail++;
      $display("FAIL reset_mid_pos: got rd=%0d wa=%0d, want rd=15 wa=14", rd_addr, wr_addr);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({wr_en, pc_we, busy, done, verr} !== 5'b0 || rd_addr !== '0 || wr_addr !== '0 ||
        wr_data !== '0 || pc_out !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got en/pcwe/busy/done/err=%b rd=%0h wa=%0h wd=%0h pc=%0h, want 0",
               {wr_en, pc_we, busy, done, verr}, rd_addr, wr_addr, wr_data, pc_out);
    end
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({wr_en, pc_we, busy} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_mid_quiet%0d: got en/pcwe/busy=%b, want 000", i, {wr_en, pc_we, busy});
      end
    end
    writes = 0;
    next_addr = 1;
    recover = 1'b1;
    for (int i = 0; i < int'(DONE_EDGE) + 4; i++) begin
      step();
      if (i == 1) recover = 1'b0;
      if (wr_en === 1'b1) begin
        writes++;
        n_checks++;
        if (wr_addr !== ADDR_W'(next_addr)) begin
          n_fail++;
          $display("FAIL reset_mid_order: got addr=%0d, want %0d", wr_addr, next_addr);
        end
        next_addr++;
      end
    end
    n_checks++;
    if (writes != int'(NREGS) - 1 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_rerun: got writes=%0d done=%b, want writes=%0d done=1",
               writes, done, NREGS - 1);
    end
  endtask

  task automatic test_held();
    int writes;
    int pcs;
    writes = 0;
    pcs = 0;
    init_rf(32'h1000, 32'h2000);
    recover = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (wr_en === 1'b1) writes++;
      if (pc_we === 1'b1) pcs++;
    end
    recover = 1'b0;
    n_checks++;
    if (writes != int'(NREGS) - 1 || pcs != 1 || {done, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL held_single: got writes=%0d pcs=%0d done/busy=%b, want %0d 1 10",
               writes, pcs, {done, busy}, NREGS - 1);
    end
    step();
  endtask

  // Core B x7 is corrupted after its write; only the compare pass can notice.
  task automatic test_verify();
    init_rf(32'h4000, 32'h5000);
    src_sel = 1'b0;
    corrupt = 1'b1;
    recover = 1'b1;
    step();
    for (int e = 1; e <= int'(DONE_EDGE); e++) begin
      step();
      if (e == 1) recover = 1'b0;
      n_checks++;
      if (verr !== (VERIFY_ON && e >= int'(NREGS) + 7)) begin
        n_fail++;
        $display("FAIL verify_err_e%0d: got %b, want %b", e, verr, VERIFY_ON && e >= int'(NREGS) + 7);
      end
    end
    corrupt = 1'b0;
    n_checks++;
    if ({done, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL verify_done: got done/busy=%b, want 10", {done, busy});
    end
    step();
    step();
    n_checks++;
    if (verr !== VERIFY_ON) begin
      n_fail++;
      $display("FAIL verify_sticky: got %b, want %b", verr, VERIFY_ON);
    end
    init_rf(32'h4000, 32'h5000);
    recover = 1'b1;
    step();
    recover = 1'b0;
    n_checks++;
    if (verr !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL verify_clear_e0: got err=%b done=%b, want 0 0", verr, done);
    end
    for (int e = 1; e <= int'(DONE_EDGE); e++) step();
    n_checks++;
    if ({done, verr} !== 2'b10) begin
      n_fail++;
      $display("FAIL verify_clean: got done/err=%b, want 10", {done, verr});
    end
  endtask

  initial begin
    test_reset();
    test_copy_a();
    test_src_b();
    test_repulse();
    test_reset_mid();
    test_held();
    test_verify();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
